// File: rtl/seg7_scan_gen.sv
// Scan/flash timing generator for a multiplexed 7-segment display, with double-buffered
// display data that is committed only when the digit scan wraps to 0.
module seg7_scan_gen #(
   parameter int unsigned SCAN_PERIOD  = 100000,
   parameter int unsigned DIGITS       = 8,
   parameter int unsigned FLASH_FRAMES = 125
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [31:0] wr_hexs,
   input  logic [7:0]  wr_point,
   input  logic [7:0]  wr_les,
   output logic        busy,
   output logic [2:0]  Scan,
   output logic [31:0] Hexs,
   output logic [7:0]  point,
   output logic [7:0]  LES,
   output logic        flash,
   output logic        frame_tick
);

   localparam int unsigned PW = $clog2(SCAN_PERIOD);
   localparam int unsigned FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

   logic [PW-1:0] presc_q;
   logic [FW-1:0] frame_q;
   logic [31:0]   shadow_hexs_q;
   logic [7:0]    shadow_point_q;
   logic [7:0]    shadow_les_q;
   logic          scan_tick;
   logic          commit;

   assign scan_tick = (presc_q == PW'(SCAN_PERIOD - 1));
   assign commit    = scan_tick && (Scan == 3'(DIGITS - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q    <= '0;
         Scan       <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= commit;
         if (scan_tick) begin
            presc_q <= '0;
            Scan    <= (Scan == 3'(DIGITS - 1)) ? 3'd0 : Scan + 3'd1;
         end else begin
            presc_q <= presc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_q <= '0;
         flash   <= 1'b0;
      end else if (commit) begin
         if (frame_q == FW'(FLASH_FRAMES - 1)) begin
            frame_q <= '0;
            flash   <= ~flash;
         end else begin
            frame_q <= frame_q + 1'b1;
         end
      end
   end

   // A write on the commit edge still commits the previous shadow; the new data stays pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy           <= 1'b0;
         shadow_hexs_q  <= '0;
         shadow_point_q <= '0;
         shadow_les_q   <= '0;
         Hexs           <= '0;
         point          <= '0;
         LES            <= '0;
      end else begin
         if (wr_en) begin
            busy           <= 1'b1;
            shadow_hexs_q  <= wr_hexs;
            shadow_point_q <= wr_point;
            shadow_les_q   <= wr_les;
         end else if (commit) begin
            busy <= 1'b0;
         end
         if (commit && busy) begin
            Hexs  <= shadow_hexs_q;
            point <= shadow_point_q;
            LES   <= shadow_les_q;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_gen.sv
// Bench for seg7_scan_gen: two instances (8 and 4 digits) checked every cycle against an
// arithmetic model driven by the edge count since reset release.
module tb_seg7_scan_gen;

   localparam int unsigned SP = 4;
   localparam int unsigned FF = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_hexs = '0;
   logic [7:0]  wr_point = '0;
   logic [7:0]  wr_les = '0;

   logic        busy_a, flash_a, tick_a, busy_b, flash_b, tick_b;
   logic [2:0]  scan_a, scan_b;
   logic [31:0] hexs_a, hexs_b;
   logic [7:0]  point_a, les_a, point_b, les_b;

   int tests = 0;
   int fails = 0;
   int unsigned n = 0;

   // Model: latest written data and whether it is still waiting for a frame boundary
   logic        m_busy[2];
   logic [31:0] m_sh_h[2], m_h[2];
   logic [7:0]  m_sh_p[2], m_p[2], m_sh_l[2], m_l[2];

   always #5 clk = ~clk;

   seg7_scan_gen #(.SCAN_PERIOD(SP), .DIGITS(8), .FLASH_FRAMES(FF)) dut_a (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_hexs(wr_hexs), .wr_point(wr_point),
      .wr_les(wr_les), .busy(busy_a), .Scan(scan_a), .Hexs(hexs_a), .point(point_a),
      .LES(les_a), .flash(flash_a), .frame_tick(tick_a)
   );

   seg7_scan_gen #(.SCAN_PERIOD(SP), .DIGITS(4), .FLASH_FRAMES(FF)) dut_b (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_hexs(wr_hexs), .wr_point(wr_point),
      .wr_les(wr_les), .busy(busy_b), .Scan(scan_b), .Hexs(hexs_b), .point(point_b),
      .LES(les_b), .flash(flash_b), .frame_tick(tick_b)
   );

   function automatic int unsigned digs(input int k);
      return (k == 0) ? 8 : 4;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         m_sh_h[k] = '0; m_sh_p[k] = '0; m_sh_l[k] = '0;
         m_h[k] = '0;    m_p[k] = '0;    m_l[k] = '0;
      end
   endtask

   task automatic model_edge(input logic we, input logic [31:0] h, input logic [7:0] p,
                             input logic [7:0] l);
      n++;
      for (int k = 0; k < 2; k++) begin
         if ((n % (SP * digs(k))) == 0) begin
            if (m_busy[k]) begin
               m_h[k] = m_sh_h[k]; m_p[k] = m_sh_p[k]; m_l[k] = m_sh_l[k];
            end
            m_busy[k] = we;
         end else if (we) begin
            m_busy[k] = 1'b1;
         end
         if (we) begin
            m_sh_h[k] = h; m_sh_p[k] = p; m_sh_l[k] = l;
         end
      end
   endtask

   task automatic check_all();
      int unsigned fa, fb;
      fa = SP * 8;
      fb = SP * 4;
      check("a_scan",  32'(scan_a), 32'((n / SP) % 8));
      check("a_tick",  32'(tick_a), 32'(n > 0 && (n % fa) == 0));
      check("a_flash", 32'(flash_a), 32'((n / (fa * FF)) % 2));
      check("a_busy",  32'(busy_a), 32'(m_busy[0]));
      check("a_hexs",  hexs_a, m_h[0]);
      check("a_point", 32'(point_a), 32'(m_p[0]));
      check("a_les",   32'(les_a), 32'(m_l[0]));
      check("b_scan",  32'(scan_b), 32'((n / SP) % 4));
      check("b_tick",  32'(tick_b), 32'(n > 0 && (n % fb) == 0));
      check("b_flash", 32'(flash_b), 32'((n / (fb * FF)) % 2));
      check("b_busy",  32'(busy_b), 32'(m_busy[1]));
      check("b_hexs",  hexs_b, m_h[1]);
      check("b_point", 32'(point_b), 32'(m_p[1]));
      check("b_les",   32'(les_b), 32'(m_l[1]));
   endtask

   task automatic step(input logic we, input logic [31:0] h, input logic [7:0] p,
                       input logic [7:0] l);
      wr_en = we; wr_hexs = h; wr_point = p; wr_les = l;
      @(posedge clk);
      model_edge(we, h, p, l);
      #1;
      check_all();
      wr_en = 1'b0;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(1'b0, 32'h0, 8'h0, 8'h0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"},  32'({busy_a, busy_b}), 32'h0);
      check({tag, "_scan"},  32'({scan_a, scan_b}), 32'h0);
      check({tag, "_hexs"},  hexs_a | hexs_b, 32'h0);
      check({tag, "_plf"},   32'({point_a, point_b, les_a, les_b}), 32'h0);
      check({tag, "_flash"}, 32'({flash_a, flash_b, tick_a, tick_b}), 32'h0);
   endtask

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 check_zero("rst0");
      @(posedge clk); @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_all();

      // Idle scan, frame ticks and two full flash half-periods
      idle(140);

      // Single write mid-frame
      idle(5);
      step(1'b1, 32'h1234_ABCD, 8'h81, 8'h00);
      check("wr_busy", 32'(busy_a), 32'h1);
      do idle(1); while ((n % 32) != 0);
      check("wr_commit", hexs_a, 32'h1234_ABCD);
      check("wr_point", 32'(point_a), 32'h81);

      // Two writes in one frame: latest wins
      idle(3);
      step(1'b1, 32'hAAAA_0001, 8'h11, 8'h22);
      step(1'b1, 32'hBBBB_0002, 8'h33, 8'h44);
      do idle(1); while ((n % 32) != 0);
      check("latest_wins", hexs_a, 32'hBBBB_0002);

      // Write coinciding with the commit edge
      step(1'b1, 32'hCAFE_0003, 8'h05, 8'h06);
      while ((n % 32) != 31) idle(1);
      step(1'b1, 32'hD00D_0004, 8'h07, 8'h08);
      check("coll_old", hexs_a, 32'hCAFE_0003);
      check("coll_busy", 32'(busy_a), 32'h1);
      idle(32);
      check("coll_new", hexs_a, 32'hD00D_0004);
      check("coll_idle", 32'(busy_a), 32'h0);

      // Asynchronous reset mid-frame with data pending
      idle(7);
      step(1'b1, 32'h5555_6666, 8'hFF, 8'hFF);
      idle(2);
      #2 rst = 1'b1;
      #1 check_zero("arst");
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      check_all();
      idle(70);

      // Randomized writes
      for (int i = 0; i < 800; i++) begin
         step(($urandom_range(0, 5) == 0), $urandom, 8'($urandom), 8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
